// File: rtl/lpddr2_access_ctrl.sv
// lpddr2_access_ctrl
// Shares one external LPDDR2 port between the instruction-fetch and data
// requesters. Each access is a single word. Data wins arbitration unless
// fetch has waited through STARVE_MAX consecutive data grants. A hung access
// is aborted after TIMEOUT cycles: err is set and read data is 32'hDEADBEEF.
//
// Optional feature: define LPDDR2_LAST_READ_BYPASS_EN to add a one-entry
// last-read buffer. A read that hits it completes without an LPDDR2 access.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   if_req/if_addr            fetch request (held until if_ack), word address
//   if_rdata/if_ack           fetch read data, valid with the one-cycle ack
//   d_req/d_we/d_addr/d_wdata data request (held until d_ack)
//   d_rdata/d_ack             data read data, valid with the one-cycle ack
//   address/write_data        LPDDR2 address and write data
//   read_req/write_req        LPDDR2 request strobes (never both high)
//   mem_wait                  LPDDR2 waitrequest
//   read_data/mem_rvalid      LPDDR2 read return
//   busy                      controller not idle
//   err                       sticky timeout flag
module lpddr2_access_ctrl #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              read_req,
  output logic              write_req,
  input  logic              mem_wait,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              err
);

  localparam int                SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  // The counter is checked before it is incremented, so an abort occurs on
  // the TIMEOUT-th cycle spent in ISSUE or WAIT_RD.
  localparam logic [7:0]        TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;

  state_t            state_q;
  logic              owner_d_q;      // 1 = data requester owns the access
  logic              we_q;
  logic [7:0]        tmo_cnt_q;
  logic [SW-1:0]     starve_cnt_q;
  logic [SW-1:0]     starve_cnt_d;

  logic              pick_data;
  logic              pick_fetch;
  logic              pick_any;
  logic              pick_read;
  logic [ADDR_W-1:0] pick_addr;
  logic              tmo_hit;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_rdata;

  always_comb begin
    pick_data    = d_req && ((starve_cnt_q < STARVE_LIM) || !if_req);
    pick_fetch   = if_req && !pick_data;
    pick_any     = pick_data || pick_fetch;
    pick_read    = pick_fetch || !d_we;
    pick_addr    = pick_data ? d_addr : if_addr;
    tmo_hit      = (tmo_cnt_q == TMO_LAST);
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_IDLE) begin
      if (pick_fetch) begin
        starve_cnt_d = '0;
      end else if (pick_data && if_req && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

`ifdef LPDDR2_LAST_READ_BYPASS_EN
  logic              byp_valid_q;
  logic [ADDR_W-1:0] byp_addr_q;
  logic [DATA_W-1:0] byp_data_q;

  assign byp_hit   = byp_valid_q && pick_read && (pick_addr == byp_addr_q);
  assign byp_rdata = byp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_valid_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_data_q  <= '0;
    end else if ((state_q == S_ISSUE || state_q == S_WAIT_RD) && tmo_hit) begin
      byp_valid_q <= 1'b0;
    end else if (state_q == S_WAIT_RD && mem_rvalid) begin
      byp_valid_q <= 1'b1;
      byp_addr_q  <= address;
      byp_data_q  <= read_data;
    end else if (state_q == S_IDLE && pick_data && d_we && (d_addr == byp_addr_q)) begin
      byp_valid_q <= 1'b0;
    end
  end
`else
  assign byp_hit   = 1'b0;
  assign byp_rdata = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_d_q    <= 1'b0;
      we_q         <= 1'b0;
      tmo_cnt_q    <= '0;
      starve_cnt_q <= '0;
      read_req     <= 1'b0;
      write_req    <= 1'b0;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            owner_d_q <= pick_data;
            we_q      <= !pick_read;
            address   <= pick_addr;
            tmo_cnt_q <= '0;
            busy      <= 1'b1;
            if (!pick_read) write_data <= d_wdata;
            if (byp_hit) begin
              // Buffer hit: DONE raises the ack one cycle later.
              state_q <= S_DONE;
              if (pick_data) d_rdata <= byp_rdata;
              else           if_rdata <= byp_rdata;
            end else begin
              state_q   <= S_ISSUE;
              read_req  <= pick_read;
              write_req <= !pick_read;
            end
          end
        end
        S_ISSUE, S_WAIT_RD: begin
          tmo_cnt_q <= tmo_cnt_q + 8'd1;
          if (tmo_hit) begin
            read_req  <= 1'b0;
            write_req <= 1'b0;
            err       <= 1'b1;
            state_q   <= S_DONE;
            d_ack     <= owner_d_q;
            if_ack    <= !owner_d_q;
            if (!we_q) begin
              if (owner_d_q) d_rdata <= ABORT_DATA;
              else           if_rdata <= ABORT_DATA;
            end
          end else if (state_q == S_ISSUE) begin
            if (!mem_wait) begin
              read_req  <= 1'b0;
              write_req <= 1'b0;
              if (we_q) begin
                state_q <= S_DONE;
                d_ack   <= owner_d_q;
                if_ack  <= !owner_d_q;
              end else begin
                state_q <= S_WAIT_RD;
              end
            end
          end else if (mem_rvalid) begin
            state_q <= S_DONE;
            d_ack   <= owner_d_q;
            if_ack  <= !owner_d_q;
            if (owner_d_q) d_rdata <= read_data;
            else           if_rdata <= read_data;
          end
        end
        S_DONE: begin
          // Normal paths enter with the ack already raised; a buffer hit
          // enters with it low and raises it here first.
          if (if_ack || d_ack) begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            d_ack  <= owner_d_q;
            if_ack <= !owner_d_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr2_access_ctrl.sv
module tb_lpddr2_access_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [26:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [26:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [26:0] address;
  logic [31:0] write_data;
  logic        read_req;
  logic        write_req;
  logic        mem_wait;
  logic [31:0] read_data;
  logic        mem_rvalid;
  logic        busy;
  logic        err;

  lpddr2_access_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .address(address), .write_data(write_data),
    .read_req(read_req), .write_req(write_req), .mem_wait(mem_wait),
    .read_data(read_data), .mem_rvalid(mem_rvalid),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory responder state
  int          stall_left  = 0;
  logic [31:0] rd_value    = '0;
  logic        no_rvalid   = 1'b0;
  logic        acc_pending = 1'b0;
  logic [31:0] acc_data    = '0;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          stall;
    int          exp_ack;
    int          exp_req;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called once per negedge: returns read data one cycle after acceptance
  // and holds mem_wait for stall_left request cycles.
  task automatic mem_step();
    mem_rvalid = acc_pending && !no_rvalid;
    read_data  = acc_pending ? acc_data : 32'h0;
    if ((read_req || write_req) && stall_left > 0) begin
      mem_wait = 1'b1;
      stall_left--;
    end else begin
      mem_wait = 1'b0;
    end
    acc_pending = read_req && !mem_wait;
    acc_data    = rd_value;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc;
    int req_cyc;
    int ack_cyc;
    bit got;
    stall_left = v.stall;
    rd_value   = v.mdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    cyc = 0; req_cyc = 0; ack_cyc = 0; got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk); mem_step(); cyc++;
      if (read_req || write_req) begin
        req_cyc++;
        chk("req_kind", {read_req, write_req}, v.we ? 2'b01 : 2'b10);
        chk("addr_stable", address, v.addr);
        if (v.we) chk("wdata_stable", write_data, v.wdata);
      end
      if (if_ack || d_ack) begin
        got = 1'b1;
        ack_cyc = cyc;
        chk("ack_owner", {d_ack, if_ack}, v.is_d ? 2'b10 : 2'b01);
        chk("ack_latency", cyc, v.exp_ack);
        chk("req_cycles", req_cyc, v.exp_req);
        if (!v.we) chk("rdata", v.is_d ? d_rdata : if_rdata, v.mdata);
        chk("busy_at_ack", busy, 1);
      end
    end
    chk("ack_seen", got, 1);
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk); mem_step();
    chk("busy_after_ack", busy, 0);
    chk("ack_one_cycle", {d_ack, if_ack}, 0);
    $display("txn %0d: %s %s addr=%h ack_cycle=%0d req_cycles=%0d", id,
             v.is_d ? "data" : "fetch", v.we ? "write" : "read", v.addr, ack_cyc, req_cyc);
  endtask

  initial begin : main
    int cyc;
    int n;
    bit got;
    byte exp_seq [10];
    byte got_c;
    vecs[0] = '{1'b0, 1'b0, 27'h10,      32'h0,        32'h12345678, 0, 3, 1};
    vecs[1] = '{1'b1, 1'b1, 27'h20,      32'hA5A5A5A5, 32'h0,        3, 5, 4};
    vecs[2] = '{1'b1, 1'b0, 27'h44,      32'h0,        32'hCAFEF00D, 2, 5, 3};
    vecs[3] = '{1'b0, 1'b0, 27'h7FFFFFF, 32'h0,        32'hFFFFFFFF, 0, 3, 1};
    vecs[4] = '{1'b1, 1'b1, 27'h0,       32'h0,        32'h0,        0, 2, 1};
    vecs[5] = '{1'b1, 1'b0, 27'h1234567, 32'h0,        32'h00000001, 1, 4, 2};
    exp_seq = '{"D", "D", "D", "D", "F", "D", "D", "D", "D", "F"};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_wait = 1'b0; read_data = '0; mem_rvalid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_reqs", {read_req, write_req}, 0);
    chk("rst_acks", {if_ack, d_ack}, 0);
    chk("rst_address", address, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    @(negedge clk); mem_step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    chk("err_after_vectors", err, 0);

    // Hung read: rvalid never arrives, abort on the 255th busy cycle.
    no_rvalid = 1'b1; stall_left = 0; rd_value = 32'h11111111;
    d_req = 1'b1; d_we = 1'b0; d_addr = 27'h55;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk); mem_step(); cyc++;
      if (d_ack || if_ack) begin
        got = 1'b1;
        chk("tmo_latency", cyc, 256);
        chk("tmo_owner", {d_ack, if_ack}, 2'b10);
        chk("tmo_rdata", d_rdata, 32'hDEADBEEF);
        chk("tmo_err", err, 1);
        chk("tmo_reqs", {read_req, write_req}, 0);
      end
    end
    chk("tmo_ack_seen", got, 1);
    d_req = 1'b0;
    @(negedge clk); mem_step();
    chk("tmo_busy_after", busy, 0);
    chk("tmo_err_sticky", err, 1);
    $display("txn 6: data read addr=%h aborted ack_cycle=%0d", 27'h55, cyc);

    // Reset while waiting for read data.
    if_req = 1'b1; if_addr = 27'h66;
    repeat (3) begin @(negedge clk); mem_step(); end
    chk("wait_rd_busy", busy, 1);
    chk("wait_rd_req_low", read_req, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_reqs", {read_req, write_req}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    chk("midrst_acks", {if_ack, d_ack}, 0);
    if_req = 1'b0;
    @(negedge clk); mem_step();
    rst = 1'b0; no_rvalid = 1'b0; acc_pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_step();
      chk("no_ack_after_rst", {if_ack, d_ack, busy}, 0);
    end
    $display("txn 7: fetch read addr=%h cut by reset", 27'h66);
    run_vec(vecs[0], 8);
    chk("err_after_rst", err, 0);

    // Both requesters held: D,D,D,D,F repeating.
    d_req = 1'b1; d_we = 1'b0; d_addr = 27'h100;
    if_req = 1'b1; if_addr = 27'h200;
    rd_value = 32'h0BADF00D; stall_left = 0;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 300) begin
      @(negedge clk); mem_step(); cyc++;
      chk("ack_overlap", {if_ack && d_ack}, 0);
      chk("req_overlap", {read_req && write_req}, 0);
      if (if_ack || d_ack) begin
        got_c = d_ack ? 8'h44 : 8'h46;
        chk("grant_order", got_c, exp_seq[n]);
        $display("txn %0d: grant %c at cycle %0d", 9 + n, got_c, cyc);
        n++;
      end
    end
    chk("starve_grants", n, 10);
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk); mem_step();
    @(negedge clk); mem_step();
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
